sign_res1_packer: RTL and testbench

- Signer-side counterpart of the first-stage verifier.
- After the signer has computed the challenge lists Lc/Lp, this block walks rounds j = 0..T-1 and requests each round's data from the signing round engine.
- It packs the response Z (seedInfo, masked_key, msgs, C, seed_lambda, aux_triangle, Cv) for challenged rounds, and seed_star for unchallenged rounds.
- Packing order is exactly the slot order the verifier consumes.

---
 rtl/sign_res1_packer.sv | 184 ++++++++++++++++++
 tb/tb_sign_res1_packer.sv | 349 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sign_res1_packer.sv
// Signer-side response packer. Walks rounds 0..T-1, fetches each round's data
// from the signing round engine, and packs the response for challenged rounds
// (listed in Lc) and seed_star for the remaining rounds. Slot 0 of every packed
// output sits in the MSBs, in the order the verifier consumes them.
module sign_res1_packer #(
  parameter int T        = 8,
  parameter int TAU      = 4,
  parameter int IW       = 5,
  localparam int SEED_W  = 1920,
  localparam int KEY_W   = 128,
  localparam int MSG_W   = 512,
  localparam int C_W     = 256,
  localparam int LAM_W   = 512,
  localparam int AUX_W   = 1024,
  localparam int CV_W    = 256,
  localparam int SS_W    = 128
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          pack_start,
  input  logic [TAU*IW-1:0]             Lc,
  output logic                          rd_req,
  output logic [7:0]                    rd_idx,
  input  logic                          rd_valid,
  input  logic [SEED_W-1:0]             rd_seed,
  input  logic [KEY_W-1:0]              rd_masked_key,
  input  logic [MSG_W-1:0]              rd_msgs,
  input  logic [C_W-1:0]                rd_C,
  input  logic [LAM_W-1:0]              rd_seed_lambda,
  input  logic [AUX_W-1:0]              rd_aux,
  input  logic [CV_W-1:0]               rd_Cv,
  input  logic [SS_W-1:0]               rd_seed_star,
  output logic [TAU*SEED_W-1:0]         seedInfo,
  output logic [TAU*KEY_W-1:0]          masked_key,
  output logic [TAU*MSG_W-1:0]          msgs,
  output logic [TAU*C_W-1:0]            C,
  output logic [TAU*LAM_W-1:0]          seed_lambda,
  output logic [TAU*AUX_W-1:0]          aux_triangle,
  output logic [TAU*CV_W-1:0]           Cv_o,
  output logic [(T-TAU)*SS_W-1:0]       seed_star_o,
  output logic                          pack_err,
  output logic                          pack_end
);

  localparam int SW = $clog2(TAU);
  localparam int UW = $clog2(T - TAU);

  typedef enum logic [2:0] {IDLE, CHECK, REQ, NEXT, DONE} state_t;

  state_t            state;
  logic [IW-1:0]     j;
  logic [SW:0]       cs;
  logic [UW:0]       cu;
  logic [TAU*IW-1:0] lc_q;
  logic              legal;
  logic              hit;

  logic [IW-1:0]     lc_in [TAU];
  logic [IW-1:0]     lc_r  [TAU];

  logic [SEED_W-1:0] seed_r [TAU];
  logic [KEY_W-1:0]  key_r  [TAU];
  logic [MSG_W-1:0]  msg_r  [TAU];
  logic [C_W-1:0]    c_r    [TAU];
  logic [LAM_W-1:0]  lam_r  [TAU];
  logic [AUX_W-1:0]  aux_r  [TAU];
  logic [CV_W-1:0]   cv_r   [TAU];
  logic [SS_W-1:0]   ss_r   [T-TAU];

  // Unpack index lists and pack slot arrays onto the flat outputs, slot 0 in MSBs
  for (genvar k = 0; k < TAU; k++) begin : g_z
    assign lc_in[k] = Lc[(TAU-1-k)*IW +: IW];
    assign lc_r[k]  = lc_q[(TAU-1-k)*IW +: IW];
    assign seedInfo[(TAU-1-k)*SEED_W +: SEED_W]  = seed_r[k];
    assign masked_key[(TAU-1-k)*KEY_W +: KEY_W]  = key_r[k];
    assign msgs[(TAU-1-k)*MSG_W +: MSG_W]        = msg_r[k];
    assign C[(TAU-1-k)*C_W +: C_W]               = c_r[k];
    assign seed_lambda[(TAU-1-k)*LAM_W +: LAM_W] = lam_r[k];
    assign aux_triangle[(TAU-1-k)*AUX_W +: AUX_W] = aux_r[k];
    assign Cv_o[(TAU-1-k)*CV_W +: CV_W]          = cv_r[k];
  end
  for (genvar u = 0; u < T - TAU; u++) begin : g_ss
    assign seed_star_o[(T-TAU-1-u)*SS_W +: SS_W] = ss_r[u];
  end

  assign rd_idx = {{(8-IW){1'b0}}, j};

  // Lc is legal when strictly ascending and the last index is below T
  always_comb begin
    legal = (lc_in[TAU-1] < IW'(T));
    for (int k = 1; k < TAU; k++) begin
      if (lc_in[k-1] >= lc_in[k]) legal = 1'b0;
    end
  end

  // Current round is challenged when it matches any registered Lc entry
  always_comb begin
    hit = 1'b0;
    for (int k = 0; k < TAU; k++) begin
      if (lc_r[k] == j) hit = 1'b1;
    end
  end

  // Control FSM plus slot writes; challenged rounds fill Z slots, others seed_star
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      j        <= '0;
      cs       <= '0;
      cu       <= '0;
      lc_q     <= '0;
      rd_req   <= 1'b0;
      pack_end <= 1'b0;
      pack_err <= 1'b0;
      for (int k = 0; k < TAU; k++) begin
        seed_r[k] <= '0;
        key_r[k]  <= '0;
        msg_r[k]  <= '0;
        c_r[k]    <= '0;
        lam_r[k]  <= '0;
        aux_r[k]  <= '0;
        cv_r[k]   <= '0;
      end
      for (int u = 0; u < T - TAU; u++) ss_r[u] <= '0;
    end else begin
      if (!pack_start) begin
        pack_end <= 1'b0;
        pack_err <= 1'b0;
      end
      case (state)
        IDLE: begin
          if (pack_start && !pack_end) state <= CHECK;
        end
        CHECK: begin
          lc_q <= Lc;
          if (legal) begin
            state    <= REQ;
            j        <= '0;
            cs       <= '0;
            cu       <= '0;
            rd_req   <= 1'b1;
            pack_err <= 1'b0;
          end else begin
            state    <= DONE;
            pack_err <= 1'b1;
            pack_end <= 1'b1;
          end
        end
        REQ: begin
          if (rd_valid) begin
            rd_req <= 1'b0;
            state  <= NEXT;
            if (hit) begin
              seed_r[cs[SW-1:0]] <= rd_seed;
              key_r[cs[SW-1:0]]  <= rd_masked_key;
              msg_r[cs[SW-1:0]]  <= rd_msgs;
              c_r[cs[SW-1:0]]    <= rd_C;
              lam_r[cs[SW-1:0]]  <= rd_seed_lambda;
              aux_r[cs[SW-1:0]]  <= rd_aux;
              cv_r[cs[SW-1:0]]   <= rd_Cv;
              cs <= cs + 1'b1;
            end else begin
              ss_r[cu[UW-1:0]] <= rd_seed_star;
              cu <= cu + 1'b1;
            end
          end
        end
        NEXT: begin
          if (j == IW'(T-1)) begin
            state    <= DONE;
            pack_end <= 1'b1;
          end else begin
            j      <= j + 1'b1;
            state  <= REQ;
            rd_req <= 1'b1;
          end
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sign_res1_packer.sv
// Self-checking bench for sign_res1_packer: a round-engine model answers
// requests with per-round patterns; a scoreboard holds expected rd_idx order
// and slot contents.
module tb_sign_res1_packer;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          pack_start = 1'b0;
  logic [19:0]   Lc = 20'h0;
  logic          rd_valid = 1'b0;
  logic          rd_req;
  logic [7:0]    rd_idx;
  logic [1919:0] rd_seed;
  logic [127:0]  rd_masked_key;
  logic [511:0]  rd_msgs;
  logic [255:0]  rd_C;
  logic [511:0]  rd_seed_lambda;
  logic [1023:0] rd_aux;
  logic [255:0]  rd_Cv;
  logic [127:0]  rd_seed_star;
  logic [7679:0] seedInfo;
  logic [511:0]  masked_key;
  logic [2047:0] msgs;
  logic [1023:0] C;
  logic [2047:0] seed_lambda;
  logic [4095:0] aux_triangle;
  logic [1023:0] Cv_o;
  logic [511:0]  seed_star_o;
  logic          pack_err;
  logic          pack_end;

  int n_cmp = 0;
  int n_bad = 0;

  logic [7:0]   exp_idx_q [$];
  logic [127:0] exp_mk_q  [$];
  logic [127:0] exp_ss_q  [$];
  logic [511:0] last_mk = '0;

  int wait_cycles = 0;
  bit spurious = 1'b0;
  int cnt = 0;
  bit spur_done = 1'b0;

  sign_res1_packer dut (
    .clk(clk), .reset(reset), .pack_start(pack_start), .Lc(Lc),
    .rd_req(rd_req), .rd_idx(rd_idx), .rd_valid(rd_valid),
    .rd_seed(rd_seed), .rd_masked_key(rd_masked_key), .rd_msgs(rd_msgs),
    .rd_C(rd_C), .rd_seed_lambda(rd_seed_lambda), .rd_aux(rd_aux),
    .rd_Cv(rd_Cv), .rd_seed_star(rd_seed_star),
    .seedInfo(seedInfo), .masked_key(masked_key), .msgs(msgs), .C(C),
    .seed_lambda(seed_lambda), .aux_triangle(aux_triangle), .Cv_o(Cv_o),
    .seed_star_o(seed_star_o), .pack_err(pack_err), .pack_end(pack_end)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] w32(input logic [7:0] tag, input logic [7:0] j);
    return {tag, 16'h0, j};
  endfunction
  function automatic logic [1919:0] seed_pat(input logic [7:0] j);
    return {60{w32(8'hA5, j)}};
  endfunction
  function automatic logic [127:0] mk_pat(input logic [7:0] j);
    return 128'h100 + {120'h0, j};
  endfunction
  function automatic logic [511:0] msg_pat(input logic [7:0] j);
    return {16{w32(8'hB1, j)}};
  endfunction
  function automatic logic [255:0] c_pat(input logic [7:0] j);
    return {8{w32(8'hC2, j)}};
  endfunction
  function automatic logic [511:0] lam_pat(input logic [7:0] j);
    return {16{w32(8'hD3, j)}};
  endfunction
  function automatic logic [1023:0] aux_pat(input logic [7:0] j);
    return {32{w32(8'hE4, j)}};
  endfunction
  function automatic logic [255:0] cv_pat(input logic [7:0] j);
    return {8{w32(8'hF5, j)}};
  endfunction
  function automatic logic [127:0] ss_pat(input logic [7:0] j);
    return {8{8'h55, j}};
  endfunction

  assign rd_seed        = seed_pat(rd_idx);
  assign rd_masked_key  = mk_pat(rd_idx);
  assign rd_msgs        = msg_pat(rd_idx);
  assign rd_C           = c_pat(rd_idx);
  assign rd_seed_lambda = lam_pat(rd_idx);
  assign rd_aux         = aux_pat(rd_idx);
  assign rd_Cv          = cv_pat(rd_idx);
  assign rd_seed_star   = ss_pat(rd_idx);

  // Round engine model: answers rd_req after wait_cycles extra cycles, optionally
  // stretching each valid pulse one cycle into the following NEXT state.
  always @(negedge clk) begin : engine
    logic was;
    was = rd_valid;
    rd_valid = 1'b0;
    if (reset) cnt = 0;
    else if (was && spurious && !rd_req && !spur_done) begin
      rd_valid = 1'b1;
      spur_done = 1'b1;
    end else if (rd_req) begin
      if (cnt >= wait_cycles) begin
        rd_valid = 1'b1;
        cnt = 0;
        spur_done = 1'b0;
      end else cnt++;
    end else cnt = 0;
  end

  task automatic do_run(input logic [19:0] lc, input int wt, input bit spur,
                        input bit exp_err, input int exp_cyc, input string tag);
    logic [4:0]   l [4];
    logic [7:0]   unch [$];
    logic [7:0]   e8;
    logic [127:0] e128;
    logic [7:0]   r;
    int cyc, run, nreq;
    bit hit;
    for (int k = 0; k < 4; k++) l[k] = lc[19-5*k -: 5];
    exp_idx_q.delete(); exp_mk_q.delete(); exp_ss_q.delete();
    if (!exp_err) begin
      for (int jj = 0; jj < 8; jj++) begin
        exp_idx_q.push_back(8'(jj));
        hit = 1'b0;
        for (int k = 0; k < 4; k++) if (l[k] == 5'(jj)) hit = 1'b1;
        if (!hit) unch.push_back(8'(jj));
      end
      for (int k = 0; k < 4; k++) exp_mk_q.push_back(mk_pat({3'b0, l[k]}));
      for (int k = 0; k < 4; k++) exp_ss_q.push_back(ss_pat(unch[k]));
    end
    wait_cycles = wt;
    spurious = spur;
    Lc = lc;
    @(negedge clk);
    pack_start = 1'b1;
    cyc = 0; run = 0; nreq = 0;
    while (!pack_end && cyc < 300) begin
      @(negedge clk); #1;
      cyc++;
      if (cyc == 3) Lc = 20'hFFFFF;
      if (rd_req) begin nreq++; run++; end
      if (rd_req && rd_valid) begin
        n_cmp++;
        if (exp_idx_q.size() == 0) begin
          n_bad++;
          $display("FAIL %s unexpected_request rd_idx=%0d required none", tag, rd_idx);
        end else begin
          e8 = exp_idx_q.pop_front();
          if (rd_idx !== e8) begin
            n_bad++;
            $display("FAIL %s rd_idx got=%0d required=%0d", tag, rd_idx, e8);
          end
        end
        n_cmp++;
        if (run != wt + 1) begin
          n_bad++;
          $display("FAIL %s req_hold got=%0d required=%0d", tag, run, wt + 1);
        end
        run = 0;
      end
    end
    Lc = lc;
    n_cmp++;
    if (pack_end !== 1'b1) begin
      n_bad++;
      $display("FAIL %s timeout pack_end=%b required=1", tag, pack_end);
    end
    n_cmp++;
    if (pack_err !== exp_err) begin
      n_bad++;
      $display("FAIL %s pack_err got=%b required=%b", tag, pack_err, exp_err);
    end
    if (exp_err) begin
      n_cmp++;
      if (cyc > 3) begin
        n_bad++;
        $display("FAIL %s err_latency got=%0d required<=3", tag, cyc);
      end
      n_cmp++;
      if (nreq != 0) begin
        n_bad++;
        $display("FAIL %s rd_req_cycles got=%0d required=0", tag, nreq);
      end
      n_cmp++;
      if (masked_key !== last_mk) begin
        n_bad++;
        $display("FAIL %s slots_kept got=%h required=%h", tag, masked_key, last_mk);
      end
    end else begin
      n_cmp++;
      if (cyc != exp_cyc) begin
        n_bad++;
        $display("FAIL %s latency got=%0d required=%0d", tag, cyc, exp_cyc);
      end
      n_cmp++;
      if (exp_idx_q.size() != 0) begin
        n_bad++;
        $display("FAIL %s rounds_missing got=%0d required=0", tag, exp_idx_q.size());
      end
      for (int k = 0; k < 4; k++) begin
        r = {3'b0, l[k]};
        e128 = exp_mk_q.pop_front();
        n_cmp++;
        if (masked_key[(3-k)*128 +: 128] !== e128) begin
          n_bad++;
          $display("FAIL %s masked_key[%0d] got=%h required=%h", tag, k, masked_key[(3-k)*128 +: 128], e128);
        end
        e128 = exp_ss_q.pop_front();
        n_cmp++;
        if (seed_star_o[(3-k)*128 +: 128] !== e128) begin
          n_bad++;
          $display("FAIL %s seed_star[%0d] got=%h required=%h", tag, k, seed_star_o[(3-k)*128 +: 128], e128);
        end
        n_cmp++;
        if (seedInfo[(3-k)*1920 +: 1920] !== seed_pat(r) || msgs[(3-k)*512 +: 512] !== msg_pat(r) ||
            C[(3-k)*256 +: 256] !== c_pat(r) || seed_lambda[(3-k)*512 +: 512] !== lam_pat(r)) begin
          n_bad++;
          $display("FAIL %s z_fields[%0d] got_C=%h required_C=%h", tag, k, C[(3-k)*256 +: 256], c_pat(r));
        end
        n_cmp++;
        if (aux_triangle[(3-k)*1024 +: 1024] !== aux_pat(r) || Cv_o[(3-k)*256 +: 256] !== cv_pat(r)) begin
          n_bad++;
          $display("FAIL %s aux_cv[%0d] got_Cv=%h required_Cv=%h", tag, k, Cv_o[(3-k)*256 +: 256], cv_pat(r));
        end
        last_mk[(3-k)*128 +: 128] = mk_pat(r);
      end
    end
  endtask

  task automatic release_start(input string tag);
    @(negedge clk);
    pack_start = 1'b0;
    @(negedge clk); #1;
    n_cmp++;
    if (pack_end !== 1'b0 || pack_err !== 1'b0) begin
      n_bad++;
      $display("FAIL %s clear end/err got=%b%b required=00", tag, pack_end, pack_err);
    end
  endtask

  task automatic check_all_zero(input string tag);
    n_cmp++;
    if (rd_req !== 1'b0 || rd_idx !== 8'h0 || pack_end !== 1'b0 || pack_err !== 1'b0) begin
      n_bad++;
      $display("FAIL %s ctrl got req=%b idx=%0d end=%b err=%b required all 0", tag, rd_req, rd_idx, pack_end, pack_err);
    end
    n_cmp++;
    if (masked_key !== '0 || seed_star_o !== '0 || seedInfo !== '0 || msgs !== '0) begin
      n_bad++;
      $display("FAIL %s slots_a got mk=%h ss=%h required 0", tag, masked_key, seed_star_o);
    end
    n_cmp++;
    if (C !== '0 || seed_lambda !== '0 || aux_triangle !== '0 || Cv_o !== '0) begin
      n_bad++;
      $display("FAIL %s slots_b got C=%h required 0", tag, C);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    check_all_zero("reset");
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_basic();
    do_run({5'd1, 5'd3, 5'd4, 5'd6}, 0, 1'b0, 1'b0, 18, "basic");
    release_start("basic");
  endtask

  task automatic test_illegal();
    do_run({5'd3, 5'd1, 5'd4, 5'd6}, 0, 1'b0, 1'b1, 0, "illegal_order");
    release_start("illegal_order");
    do_run({5'd0, 5'd2, 5'd4, 5'd8}, 0, 1'b0, 1'b1, 0, "illegal_range");
    release_start("illegal_range");
    do_run({5'd2, 5'd2, 5'd4, 5'd6}, 0, 1'b0, 1'b1, 0, "illegal_dup");
    release_start("illegal_dup");
  endtask

  task automatic test_wait();
    do_run({5'd1, 5'd3, 5'd4, 5'd6}, 4, 1'b1, 1'b0, 50, "wait5");
    spurious = 1'b0;
    release_start("wait5");
  endtask

  task automatic test_reset_mid();
    int cyc;
    wait_cycles = 0;
    Lc = {5'd1, 5'd3, 5'd4, 5'd6};
    @(negedge clk);
    pack_start = 1'b1;
    cyc = 0;
    while (!(rd_req && rd_idx == 8'd3) && cyc < 40) begin
      @(negedge clk); #1;
      cyc++;
    end
    n_cmp++;
    if (!(rd_req && rd_idx == 8'd3)) begin
      n_bad++;
      $display("FAIL reset_mid reach_j3 got idx=%0d required=3", rd_idx);
    end
    reset = 1'b1;
    #1;
    check_all_zero("reset_mid");
    pack_start = 1'b0;
    last_mk = '0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    do_run({5'd1, 5'd3, 5'd4, 5'd6}, 0, 1'b0, 1'b0, 18, "restart");
    release_start("restart");
  endtask

  task automatic test_hold_restart();
    int bad;
    do_run({5'd0, 5'd2, 5'd5, 5'd7}, 0, 1'b0, 1'b0, 18, "hold_first");
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk); #1;
      if (rd_req !== 1'b0 || pack_end !== 1'b1) bad++;
    end
    n_cmp++;
    if (bad != 0) begin
      n_bad++;
      $display("FAIL hold no_rerun bad_cycles=%0d required=0", bad);
    end
    release_start("hold");
    do_run({5'd4, 5'd5, 5'd6, 5'd7}, 0, 1'b0, 1'b0, 18, "hold_second");
    release_start("hold_second");
  endtask

  initial begin
    test_reset();
    test_basic();
    test_illegal();
    test_wait();
    test_reset_mid();
    test_hold_restart();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
